// File: rtl/vga_frame_scanout.sv
// Pixel sink and VGA scan-out: registers the plot stream into an external
// dual-port framebuffer and scans it out as 640x480 VGA with 2x pixel doubling.
module vga_frame_scanout #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [5:0]  colour,
    input  logic        plot,
    output logic [16:0] fb_waddr,
    output logic [5:0]  fb_wdata,
    output logic        fb_we,
    output logic [16:0] fb_raddr,
    input  logic [5:0]  fb_rdata,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk,
    output logic        frame_start,
    output logic [7:0]  drop_count
);

    localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
    localparam logic [9:0] H_SYNC_LO  = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_HI  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
    localparam logic [9:0] V_SYNC_LO  = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_HI  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    // plot is a valid strobe with no back-pressure: the sink is always ready,
    // so every cycle with plot=1 is one accepted pixel.
    logic        w_in_range;
    logic [16:0] w_waddr;

    logic        r_we;
    logic [16:0] r_waddr;
    logic [5:0]  r_wdata;
    logic [7:0]  r_drop;

    assign w_in_range = (x < 9'(FB_W)) && (y < 8'(FB_H));
    // y*320 + x as shifts; the framebuffer row pitch is fixed at 320.
    assign w_waddr = ({9'b0, y} << 8) + ({9'b0, y} << 6) + {8'b0, x};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_drop  <= '0;
        end else begin
            r_we    <= plot && w_in_range;
            r_waddr <= w_waddr;
            r_wdata <= colour;
            if (plot && !w_in_range && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
        end
    end

    logic        r_pix_en;
    logic        r_vga_clk;
    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic [16:0] r_raddr;
    logic        r_a_hs;
    logic        r_a_vs;
    logic        r_a_blank_n;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic [5:0]  r_rgb;

    logic        w_visible;
    logic        w_hs;
    logic        w_vs;
    logic [16:0] w_raddr;

    assign w_visible = (r_h < H_VIS_L) && (r_v < V_VIS_L);
    assign w_hs      = !((r_h >= H_SYNC_LO) && (r_h <= H_SYNC_HI));
    assign w_vs      = !((r_v >= V_SYNC_LO) && (r_v <= V_SYNC_HI));
    assign w_raddr   = w_visible ? (({8'b0, r_v[9:1]} << 8) + ({8'b0, r_v[9:1]} << 6)
                                    + {8'b0, r_h[9:1]}) : 17'd0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pix_en  <= 1'b0;
            r_vga_clk <= 1'b0;
            r_h       <= '0;
            r_v       <= '0;
        end else begin
            r_pix_en  <= ~r_pix_en;
            r_vga_clk <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    // Stage A issues the read and holds sync/blank for the same counter value;
    // stage B lands one pixel period later, together with the RAM data.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_raddr     <= '0;
            r_a_hs      <= 1'b1;
            r_a_vs      <= 1'b1;
            r_a_blank_n <= 1'b0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_blank_n   <= 1'b0;
            r_rgb       <= '0;
        end else if (r_pix_en) begin
            r_raddr     <= w_raddr;
            r_a_hs      <= w_hs;
            r_a_vs      <= w_vs;
            r_a_blank_n <= w_visible;
            r_hs        <= r_a_hs;
            r_vs        <= r_a_vs;
            r_blank_n   <= r_a_blank_n;
            r_rgb       <= r_a_blank_n ? fb_rdata : 6'd0;
        end
    end

    assign fb_we       = r_we;
    assign fb_waddr    = r_waddr;
    assign fb_wdata    = r_wdata;
    assign drop_count  = r_drop;
    assign fb_raddr    = r_raddr;
    assign vga_r       = {4{r_rgb[5:4]}};
    assign vga_g       = {4{r_rgb[3:2]}};
    assign vga_b       = {4{r_rgb[1:0]}};
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = r_vga_clk;
    assign frame_start = r_pix_en && (r_h == 10'd0) && (r_v == 10'd0);

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Bench for vga_frame_scanout: full-width lines with a shortened vertical
// timing so whole frames fit in a short run.
module tb_vga_frame_scanout;

  localparam int V_VIS      = 4;
  localparam int V_FP       = 1;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 1;
  localparam int V_TOTAL    = 8;
  localparam int H_TOTAL    = 800;
  localparam int FRAME_CLKS = 2 * H_TOTAL * V_TOTAL;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #10 clock = ~clock;

  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic [5:0]  colour = '0;
  logic        plot = 1'b0;
  logic [16:0] fb_waddr;
  logic [5:0]  fb_wdata;
  logic        fb_we;
  logic [16:0] fb_raddr;
  logic [5:0]  fb_rdata = '0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;
  logic [7:0]  drop_count;

  vga_frame_scanout #(
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clock(clock), .resetn(resetn),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_we(fb_we),
    .fb_raddr(fb_raddr), .fb_rdata(fb_rdata),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_clk(vga_clk),
    .frame_start(frame_start), .drop_count(drop_count)
  );

  // Model framebuffer: 1-clock read latency, read returns old data on collision.
  logic [5:0] mem [0:131071];
  logic       mem_clear = 1'b0;
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 131072; i++) mem[i] <= 6'h00;
      mem[0] <= 6'h3F;
      mem[1] <= 6'h03;
    end else if (fb_we) begin
      mem[fb_waddr] <= fb_wdata;
    end
    fb_rdata <= mem[fb_raddr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write scoreboard: {cycle[31:0], addr[16:0], data[5:0]}
  logic [54:0] exp_q[$];
  logic [54:0] we_e;
  always @(negedge clock) begin
    if (resetn && fb_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", fb_waddr, fb_wdata);
      end else begin
        we_e = exp_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(we_e[54:23]));
        chk("wr_addr", 64'(fb_waddr), 64'(we_e[22:6]));
        chk("wr_data", 64'(fb_wdata), 64'(we_e[5:0]));
      end
    end
  end

  // Pixel/timing monitor, one sample per pixel period.
  logic [23:0] pix_q[$];
  logic [23:0] pix_e;
  logic        mon_en = 1'b0;
  int hs_run = 0, vs_run = 0, n_vis = 0, n_blank_bad = 0, n_hs_lines = 0, n_vs_runs = 0;
  always @(negedge clock) begin
    if (mon_en && vga_clk) begin
      if (vga_blank_n) begin
        n_vis++;
        if (pix_q.size() > 0) begin
          pix_e = pix_q.pop_front();
          chk("pixel_rgb", 64'({vga_r, vga_g, vga_b}), 64'(pix_e));
        end
      end else if ({vga_r, vga_g, vga_b} != 24'h0) begin
        n_blank_bad++;
      end
      if (!vga_hs) hs_run++;
      else if (hs_run != 0) begin
        chk("hs_low_len", 64'(hs_run), 64'd96);
        hs_run = 0;
        n_hs_lines++;
      end
      if (!vga_vs) vs_run++;
      else if (vs_run != 0) begin
        chk("vs_low_len", 64'(vs_run), 64'(V_SYNC * H_TOTAL));
        vs_run = 0;
        n_vs_runs++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_plot(input logic [8:0] px, input logic [7:0] py, input logic [5:0] pc,
                            input logic ok, input logic [16:0] ea);
    @(negedge clock);
    x = px;
    y = py;
    colour = pc;
    plot = 1'b1;
    if (ok) exp_q.push_back({32'(cyc + 1), ea, pc});
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    plot = 1'b0;
    repeat (n - 1) @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fb_we"}, 64'(fb_we), 64'd0);
    chk({tag, "_fb_waddr"}, 64'(fb_waddr), 64'd0);
    chk({tag, "_fb_wdata"}, 64'(fb_wdata), 64'd0);
    chk({tag, "_fb_raddr"}, 64'(fb_raddr), 64'd0);
    chk({tag, "_rgb"}, 64'({vga_r, vga_g, vga_b}), 64'd0);
    chk({tag, "_hs"}, 64'(vga_hs), 64'd1);
    chk({tag, "_vs"}, 64'(vga_vs), 64'd1);
    chk({tag, "_blank_n"}, 64'(vga_blank_n), 64'd0);
    chk({tag, "_vga_clk"}, 64'(vga_clk), 64'd0);
    chk({tag, "_frame_start"}, 64'(frame_start), 64'd0);
    chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    chk({tag, "_sync_n"}, 64'(vga_sync_n), 64'd0);
  endtask

  // Plot vectors: x, y, colour, expected address (hand-computed y*320+x)
  typedef struct packed {
    logic [8:0]  px;
    logic [7:0]  py;
    logic [5:0]  pc;
    logic [16:0] ea;
  } wvec_t;
  wvec_t wv [8];

  int n_fs;
  int gap;
  logic found;

  initial begin
    wv[0] = '{px: 9'd5,   py: 8'd2,   pc: 6'b110000, ea: 17'd645};
    wv[1] = '{px: 9'd0,   py: 8'd0,   pc: 6'h01,     ea: 17'd0};
    wv[2] = '{px: 9'd319, py: 8'd0,   pc: 6'h02,     ea: 17'd319};
    wv[3] = '{px: 9'd0,   py: 8'd1,   pc: 6'h03,     ea: 17'd320};
    wv[4] = '{px: 9'd319, py: 8'd239, pc: 6'h3F,     ea: 17'd76799};
    wv[5] = '{px: 9'd160, py: 8'd120, pc: 6'h15,     ea: 17'd38560};
    wv[6] = '{px: 9'd1,   py: 8'd2,   pc: 6'h2A,     ea: 17'd641};
    wv[7] = '{px: 9'd7,   py: 8'd3,   pc: 6'h10,     ea: 17'd967};

    // Reset and framebuffer preload: addr0=3F, addr1=03, all else 0.
    mem_clear = 1'b1;
    repeat (3) @(negedge clock);
    mem_clear = 1'b0;

    // Visible lines 0 and 1 both read row 0: pixels 0-1 white, 2-3 blue.
    for (int l = 0; l < V_VIS; l++)
      for (int h = 0; h < 640; h++) begin
        if (l < 2 && h < 2) pix_q.push_back(24'hFFFFFF);
        else if (l < 2 && h < 4) pix_q.push_back(24'h0000FF);
        else pix_q.push_back(24'h000000);
      end

    check_reset_vals("rst");
    resetn = 1'b1;
    mon_en = 1'b1;

    // One full frame: sync widths, pixel content, blanking.
    n_fs = 0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      @(negedge clock);
      if (frame_start) n_fs++;
    end
    mon_en = 1'b0;
    chk("frame_start_count", 64'(n_fs), 64'd1);
    chk("visible_pixels", 64'(n_vis), 64'(640 * V_VIS));
    chk("blank_rgb_nonzero", 64'(n_blank_bad), 64'd0);
    chk("hs_lines", 64'(n_hs_lines), 64'(V_TOTAL));
    chk("vs_pulses", 64'(n_vs_runs), 64'd1);
    chk("pixels_left", 64'(pix_q.size()), 64'd0);

    // Write path: single plot, then a back-to-back burst.
    drive_plot(wv[0].px, wv[0].py, wv[0].pc, 1'b1, wv[0].ea);
    idle(3);
    for (int i = 1; i < 8; i++) drive_plot(wv[i].px, wv[i].py, wv[i].pc, 1'b1, wv[i].ea);
    idle(3);
    chk("writes_left", 64'(exp_q.size()), 64'd0);

    // Out-of-range plots: no write, saturating drop counter.
    drive_plot(9'd320, 8'd0, 6'h3F, 1'b0, 17'd0);
    drive_plot(9'd0, 8'd240, 6'h3F, 1'b0, 17'd0);
    drive_plot(9'd511, 8'd0, 6'h3F, 1'b0, 17'd0);
    idle(1);
    chk("drop_count_3", 64'(drop_count), 64'd3);
    for (int i = 0; i < 300; i++) drive_plot(9'd320, 8'd17, 6'h01, 1'b0, 17'd0);
    idle(2);
    chk("drop_count_sat", 64'(drop_count), 64'd255);

    // Mid-frame reset at h=300, v=2.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clock);
      if (frame_start) begin
        found = 1'b1;
        break;
      end
    end
    chk("frame_start_seen", 64'(found), 64'd1);
    repeat (2 * (2 * H_TOTAL + 300)) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check_reset_vals("midrst");
    resetn = 1'b1;
    @(negedge clock);
    chk("fs_after_reset", 64'(frame_start), 64'd1);
    gap = 0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clock);
      gap++;
      if (frame_start) break;
    end
    chk("frame_period", 64'(gap), 64'(FRAME_CLKS));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
